mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage controller for the RV32I pipeline. Consumes the EX/MEM buffer (`ex_mem_reg`) and drives a data memory through a req/ready handshake. Formats store byte-enables and load sign/zero extension. Stalls upstream stages while an access is outstanding, then produces the MEM/WB buffer (`mem_wb_reg`). Sits between the EX/MEM register and the WB mux, replacing the direct single-cycle data-memory hookup.

## Interface
- `DM_ADDR_W`, default 9: data-memory byte-address width.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `ex_mem_in`  in  `ex_mem_reg`  EX/MEM buffer contents.
- `ex_mem_valid`  in  1  the entry is a real instruction (0 = bubble).
- `mem_req`  out  1  access request; held until `mem_ready`.
- `mem_we`  out  1  1 = store, 0 = load.
- `mem_addr`  out  `DM_ADDR_W`  word-aligned byte address (bits [1:0] = 0).
- `mem_wdata`  out  32  store data, lane-replicated.
- `mem_be`  out  4  byte enables (stores); 4'b1111 for loads.
- `mem_ready`  in  1  memory accepts/completes the request this cycle; `mem_rdata` valid with it.
- `mem_rdata`  in  32  raw word read data.
- `mem_stall`  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- `mem_wb_out`  out  `mem_wb_reg`  MEM/WB buffer (registered).
- `mem_wb_valid`  out  1  `mem_wb_out` holds a real instruction.
- `mem_fault`  out  1  one-cycle pulse: misaligned/illegal access squashed.

## Operation
- A memory op is `ex_mem_valid & (MemRead | MemWrite)`.
- Illegal access, any of:
  - MemRead & MemWrite both set;
  - func3 not in {000,001,010,100,101} for loads, or not in {000,001,010} for stores;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Non-memory op or bubble: no stall. At the edge, load `mem_wb_out` from `ex_mem_in` with MemReadData = 0, and set `mem_wb_valid` = `ex_mem_valid`.
  - Illegal memory op: no stall and no request. Pulse `mem_fault` at the edge, load a bubble, stay in IDLE.
  - Legal memory op: `mem_stall`=1 (combinational). Latch addr/wdata/be/we/func3 into internal request registers, load a bubble, go to REQ.
- REQ:
  - `mem_req`=1 and `mem_stall`=1. Request fields stay stable until `mem_ready`.
  - `mem_ready`=0: load a bubble, stay in REQ.
  - `mem_ready`=1: load `mem_wb_out` from the held `ex_mem_in`. MemReadData = formatted `mem_rdata` for loads, 0 for stores. Go to DONE.
- DONE:
  - `mem_stall`=0, so the pipeline advances past the completed instruction.
  - No re-issue. At the edge, load a bubble and go to IDLE.
- Bubble: all fields 0, RegWrite=0, `mem_wb_valid`=0.
- Field copy: RegWrite, MemtoReg, Pc_Imm, Pc_Four, Imm_Out, Alu_Result, rd and Curr_Instr are copied from `ex_mem_in`.
- Store formatting:
  - SB: be = 4'b0001<<a[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011<<a[1:0], wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111, wdata = RD_Two.
- Load formatting: select the byte/half lane by a[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.

## Timing
- Reset values: state=IDLE, `mem_wb_out`=bubble, `mem_wb_valid`=0, `mem_req`=0, `mem_fault`=0, `mem_stall`=0. Internal request registers = 0.
- Non-memory op latency: 1 cycle, no stall.
- Memory op: 1 detect cycle + N REQ cycles (N ≥ 1, ends on `mem_ready`) + 1 DONE cycle.
  - Stall asserted for 1+N cycles.
  - `mem_wb_valid` is high only during DONE.
- `mem_ready` outside REQ is ignored.
- `mem_rdata` is sampled only in REQ with `mem_ready`=1.
- `reset` in REQ/DONE: IDLE next cycle, `mem_req` drops. The outstanding access is abandoned and the memory must tolerate it.
- `reset` has priority over `mem_ready` in the same cycle.
- `ex_mem_in` is guaranteed stable while `mem_stall`=1.

## Structure
- Add to `Pipe_Buf_Reg_PKG`:
  - load/store func3 localparams (`F3_LB`..`F3_LHU`);
  - a `MEM_WB_BUBBLE` constant of type `mem_wb_reg`.
- FSM state enum is local to the module.
- One combinational sub-module, `mem_lane_align`: addr[1:0], func3, rs2, rdata → be, wdata, formatted load data, illegal flag.

## Test plan
- ALU op (RegWrite=1, rd=5, Alu_Result=0x1234): `mem_wb_out` next cycle with rd=5, Alu_Result=0x1234; `mem_stall` never high.
- LW at 0x10, `mem_ready` after 3 REQ cycles, rdata=0xDEADBEEF: stall high 4 cycles; MemReadData=0xDEADBEEF in DONE; `mem_addr`=0x10 stable throughout.
- LB at 0x13, rdata=0x80112233: MemReadData=0xFFFFFF80. LBU at the same address: 0x00000080. LHU at 0x12: 0x00008011.
- SH at 0x06, RD_Two=0xAAAA5555: mem_we=1, be=4'b1100, wdata=0x55555555; MemReadData=0.
- LW at 0x02: `mem_fault` pulses, `mem_req` stays 0, no stall, `mem_wb_valid`=0.
- `reset` asserted in the 2nd REQ cycle: next cycle state IDLE, `mem_req`=0, `mem_wb_valid`=0; a following ALU op passes through normally.

Source files
------------

// File: rtl/pipe_buf_reg_pkg.sv
// Pipeline buffer types shared by the MEM stage: EX/MEM and MEM/WB records,
// load/store func3 encodings and the MEM/WB bubble constant.
package Pipe_Buf_Reg_PKG;

    typedef struct packed {
        logic        RegWrite;
        logic        MemtoReg;
        logic        MemRead;
        logic        MemWrite;
        logic [31:0] Pc_Imm;
        logic [31:0] Pc_Four;
        logic [31:0] Imm_Out;
        logic [31:0] Alu_Result;
        logic [31:0] RD_Two;
        logic [4:0]  rd;
        logic [2:0]  func3;
        logic [31:0] Curr_Instr;
    } ex_mem_reg;

    typedef struct packed {
        logic        RegWrite;
        logic        MemtoReg;
        logic [31:0] Pc_Imm;
        logic [31:0] Pc_Four;
        logic [31:0] Imm_Out;
        logic [31:0] Alu_Result;
        logic [31:0] MemReadData;
        logic [4:0]  rd;
        logic [31:0] Curr_Instr;
    } mem_wb_reg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam mem_wb_reg MEM_WB_BUBBLE = '0;

    // Build a MEM/WB record from the EX/MEM entry plus the formatted load word.
    function automatic mem_wb_reg to_mem_wb(ex_mem_reg e, logic [31:0] rd_data);
        mem_wb_reg w;
        w.RegWrite    = e.RegWrite;
        w.MemtoReg    = e.MemtoReg;
        w.Pc_Imm      = e.Pc_Imm;
        w.Pc_Four     = e.Pc_Four;
        w.Imm_Out     = e.Imm_Out;
        w.Alu_Result  = e.Alu_Result;
        w.MemReadData = rd_data;
        w.rd          = e.rd;
        w.Curr_Instr  = e.Curr_Instr;
        return w;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: store byte-enables/replicated data, load extension and
// legality of the access size/alignment.
module mem_lane_align
    import Pipe_Buf_Reg_PKG::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  func3,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        illegal
);

    logic [31:0] shifted;

    // Lane formatting and legality decode.
    always_comb begin
        be        = 4'b1111;
        wdata     = rs2;
        load_data = rdata;
        illegal   = 1'b0;
        shifted   = rdata >> {addr_lo, 3'b000};
        if (mem_read && mem_write) begin
            illegal = 1'b1;
        end else if (mem_write) begin
            case (func3)
                F3_SB: begin
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{rs2[7:0]}};
                end
                F3_SH: begin
                    be      = 4'b0011 << addr_lo;
                    wdata   = {2{rs2[15:0]}};
                    illegal = addr_lo[0];
                end
                F3_SW:   illegal = (addr_lo != 2'b00);
                default: illegal = 1'b1;
            endcase
        end else if (mem_read) begin
            case (func3)
                F3_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
                F3_LBU: load_data = {24'h0, shifted[7:0]};
                F3_LH: begin
                    load_data = {{16{shifted[15]}}, shifted[15:0]};
                    illegal   = addr_lo[0];
                end
                F3_LHU: begin
                    load_data = {16'h0, shifted[15:0]};
                    illegal   = addr_lo[0];
                end
                F3_LW:   illegal = (addr_lo != 2'b00);
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: issues data-memory requests over a req/ready
// handshake, stalls upstream while outstanding, and produces the MEM/WB buffer.
module mem_access_unit
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int unsigned DM_ADDR_W = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  ex_mem_reg            ex_mem_in,
    input  logic                 ex_mem_valid,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [DM_ADDR_W-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_be,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_rdata,
    output logic                 mem_stall,
    output mem_wb_reg            mem_wb_out,
    output logic                 mem_wb_valid,
    output logic                 mem_fault
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e               state_q, state_d;
    logic                 req_we_q, req_we_d;
    logic [DM_ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [1:0]           req_lo_q, req_lo_d;
    logic [31:0]          req_wdata_q, req_wdata_d;
    logic [3:0]           req_be_q, req_be_d;
    logic [2:0]           req_func3_q, req_func3_d;
    mem_wb_reg            wb_q, wb_d;
    logic                 wb_valid_q, wb_valid_d;
    logic                 fault_q, fault_d;

    logic        mem_op;
    logic [1:0]  al_lo;
    logic [2:0]  al_func3;
    logic        al_read, al_write;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_load;
    logic        al_illegal;

    assign mem_op = ex_mem_valid & (ex_mem_in.MemRead | ex_mem_in.MemWrite);

    // In REQ the aligner formats the returning word from the latched request.
    always_comb begin
        al_lo    = ex_mem_in.Alu_Result[1:0];
        al_func3 = ex_mem_in.func3;
        al_read  = ex_mem_in.MemRead;
        al_write = ex_mem_in.MemWrite;
        if (state_q == StReq) begin
            al_lo    = req_lo_q;
            al_func3 = req_func3_q;
            al_read  = ~req_we_q;
            al_write = req_we_q;
        end
    end

    mem_lane_align u_align (
        .addr_lo   (al_lo),
        .func3     (al_func3),
        .mem_read  (al_read),
        .mem_write (al_write),
        .rs2       (ex_mem_in.RD_Two),
        .rdata     (mem_rdata),
        .be        (al_be),
        .wdata     (al_wdata),
        .load_data (al_load),
        .illegal   (al_illegal)
    );

    // Next-state, request latching, MEM/WB formation and stall.
    always_comb begin
        state_d     = state_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_lo_d    = req_lo_q;
        req_wdata_d = req_wdata_q;
        req_be_d    = req_be_q;
        req_func3_d = req_func3_q;
        wb_d        = MEM_WB_BUBBLE;
        wb_valid_d  = 1'b0;
        fault_d     = 1'b0;
        mem_stall   = 1'b0;
        case (state_q)
            StIdle: begin
                if (!mem_op) begin
                    if (ex_mem_valid) wb_d = to_mem_wb(ex_mem_in, 32'h0);
                    wb_valid_d = ex_mem_valid;
                end else if (al_illegal) begin
                    fault_d = 1'b1;
                end else begin
                    mem_stall   = 1'b1;
                    req_we_d    = ex_mem_in.MemWrite;
                    req_addr_d  = {ex_mem_in.Alu_Result[DM_ADDR_W-1:2], 2'b00};
                    req_lo_d    = ex_mem_in.Alu_Result[1:0];
                    req_wdata_d = al_wdata;
                    req_be_d    = al_be;
                    req_func3_d = ex_mem_in.func3;
                    state_d     = StReq;
                end
            end
            StReq: begin
                mem_stall = 1'b1;
                if (mem_ready) begin
                    wb_d       = to_mem_wb(ex_mem_in, req_we_q ? 32'h0 : al_load);
                    wb_valid_d = 1'b1;
                    state_d    = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset abandons any outstanding access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_lo_q    <= 2'b00;
            req_wdata_q <= 32'h0;
            req_be_q    <= 4'h0;
            req_func3_q <= 3'b000;
            wb_q        <= MEM_WB_BUBBLE;
            wb_valid_q  <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_lo_q    <= req_lo_d;
            req_wdata_q <= req_wdata_d;
            req_be_q    <= req_be_d;
            req_func3_q <= req_func3_d;
            wb_q        <= wb_d;
            wb_valid_q  <= wb_valid_d;
            fault_q     <= fault_d;
        end
    end

    assign mem_req      = (state_q == StReq);
    assign mem_we       = req_we_q;
    assign mem_addr     = req_addr_q;
    assign mem_wdata    = req_wdata_q;
    assign mem_be       = req_be_q;
    assign mem_wb_out   = wb_q;
    assign mem_wb_valid = wb_valid_q;
    assign mem_fault    = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus scoreboard queue.
module tb_mem_access_unit;
    import Pipe_Buf_Reg_PKG::*;

    logic        clk = 1'b0;
    logic        reset;
    ex_mem_reg   ex_mem_in;
    logic        ex_mem_valid;
    logic        mem_req, mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    mem_wb_reg   mem_wb_out;
    logic        mem_wb_valid, mem_fault;

    always #5 clk = ~clk;

    mem_access_unit #(.DM_ADDR_W(9)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_mem_in    (ex_mem_in),
        .ex_mem_valid (ex_mem_valid),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .mem_stall    (mem_stall),
        .mem_wb_out   (mem_wb_out),
        .mem_wb_valid (mem_wb_valid),
        .mem_fault    (mem_fault)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int unsigned delay;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] mrd;
    } vec_t;

    vec_t      vecs[16];
    mem_wb_reg sb_q[$];

    function automatic ex_mem_reg make_ex(vec_t v, int idx);
        ex_mem_reg e;
        e.RegWrite   = ~v.wr;
        e.MemtoReg   = v.rd;
        e.MemRead    = v.rd;
        e.MemWrite   = v.wr;
        e.Pc_Imm     = 32'h1000 + idx;
        e.Pc_Four    = 32'h2000 + idx;
        e.Imm_Out    = 32'h3000 + idx;
        e.Alu_Result = v.addr;
        e.RD_Two     = v.rs2;
        e.rd         = 5'(idx + 5);
        e.func3      = v.f3;
        e.Curr_Instr = 32'hC0DE0000 | idx;
        return e;
    endfunction

    function automatic mem_wb_reg model(ex_mem_reg e, logic [31:0] mrd);
        mem_wb_reg w;
        w.RegWrite    = e.RegWrite;
        w.MemtoReg    = e.MemtoReg;
        w.Pc_Imm      = e.Pc_Imm;
        w.Pc_Four     = e.Pc_Four;
        w.Imm_Out     = e.Imm_Out;
        w.Alu_Result  = e.Alu_Result;
        w.MemReadData = mrd;
        w.rd          = e.rd;
        w.Curr_Instr  = e.Curr_Instr;
        return w;
    endfunction

    task automatic pop_cmp(string name);
        mem_wb_reg exp;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fails++;
            $display("FAIL %s: got %0h expected scoreboard entry (queue empty)", name, mem_wb_out);
        end else begin
            exp = sb_q.pop_front();
            n_checks--;
            check({name, "_wb"}, 256'(mem_wb_out), 256'(exp));
            check({name, "_mrd"}, 256'(mem_wb_out.MemReadData), 256'(exp.MemReadData));
        end
    endtask

    task automatic run_vec(vec_t v, int idx);
        ex_mem_reg  e;
        logic       memop;
        int         stalls;
        logic [8:0] exp_addr;
        string      nm;
        nm       = $sformatf("v%0d", idx);
        e        = make_ex(v, idx);
        memop    = v.rd | v.wr;
        exp_addr = v.addr[8:0] & 9'h1FC;
        stalls   = 0;
        @(negedge clk);
        ex_mem_in    = e;
        ex_mem_valid = 1'b1;
        mem_ready    = 1'b0;
        mem_rdata    = v.rdata;
        if (!memop) sb_q.push_back(model(e, 32'h0));
        else if (!v.fault) sb_q.push_back(model(e, v.mrd));
        #1;
        check({nm, "_detect_stall"}, 256'(mem_stall), 256'(memop & ~v.fault));
        if (mem_stall) stalls++;
        if (!memop) begin
            @(negedge clk);
            ex_mem_valid = 1'b0;
            check({nm, "_valid"}, 256'(mem_wb_valid), 256'(1));
            pop_cmp(nm);
        end else if (v.fault) begin
            @(negedge clk);
            ex_mem_valid = 1'b0;
            check({nm, "_fault"}, 256'(mem_fault), 256'(1));
            check({nm, "_noreq"}, 256'(mem_req), 256'(0));
            check({nm, "_novalid"}, 256'(mem_wb_valid), 256'(0));
            @(negedge clk);
            check({nm, "_fault_pulse"}, 256'(mem_fault), 256'(0));
        end else begin
            for (int c = 0; c < int'(v.delay); c++) begin
                @(negedge clk);
                if (mem_stall) stalls++;
                check({nm, "_req"}, 256'(mem_req), 256'(1));
                check({nm, "_addr"}, 256'(mem_addr), 256'(exp_addr));
                check({nm, "_we"}, 256'(mem_we), 256'(v.wr));
                check({nm, "_be"}, 256'(mem_be), 256'(v.be));
                check({nm, "_req_valid"}, 256'(mem_wb_valid), 256'(0));
                if (v.wr) check({nm, "_wdata"}, 256'(mem_wdata), 256'(v.wdata));
                if (c == int'(v.delay) - 1) mem_ready = 1'b1;
            end
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_stall) stalls++;
            check({nm, "_done_valid"}, 256'(mem_wb_valid), 256'(1));
            check({nm, "_done_req"}, 256'(mem_req), 256'(0));
            check({nm, "_stall_cycles"}, 256'(stalls), 256'(v.delay + 1));
            pop_cmp(nm);
            ex_mem_valid = 1'b0;
            @(negedge clk);
            check({nm, "_after_valid"}, 256'(mem_wb_valid), 256'(0));
        end
    endtask

    task automatic set_vec(int i, logic rd, logic wr, logic [2:0] f3, logic [31:0] addr,
                           logic [31:0] rs2, logic [31:0] rdata, int unsigned delay,
                           logic fault, logic [3:0] be, logic [31:0] wdata, logic [31:0] mrd);
        vecs[i] = '{rd, wr, f3, addr, rs2, rdata, delay, fault, be, wdata, mrd};
    endtask

    initial begin
        ex_mem_reg e;
        set_vec(0,  0, 0, 3'b000, 32'h1234, 0, 0, 0, 0, 4'hF, 0, 0);
        set_vec(1,  1, 0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 3, 0, 4'hF, 0, 32'hDEADBEEF);
        set_vec(2,  1, 0, 3'b000, 32'h13, 0, 32'h80112233, 1, 0, 4'hF, 0, 32'hFFFFFF80);
        set_vec(3,  1, 0, 3'b100, 32'h13, 0, 32'h80112233, 2, 0, 4'hF, 0, 32'h00000080);
        set_vec(4,  1, 0, 3'b101, 32'h12, 0, 32'h80112233, 1, 0, 4'hF, 0, 32'h00008011);
        set_vec(5,  1, 0, 3'b001, 32'h12, 0, 32'h80112233, 1, 0, 4'hF, 0, 32'hFFFF8011);
        set_vec(6,  0, 1, 3'b001, 32'h06, 32'hAAAA5555, 0, 2, 0, 4'b1100, 32'h55555555, 0);
        set_vec(7,  0, 1, 3'b000, 32'h01, 32'h000000A5, 0, 1, 0, 4'b0010, 32'hA5A5A5A5, 0);
        set_vec(8,  0, 1, 3'b010, 32'h08, 32'h12345678, 0, 1, 0, 4'b1111, 32'h12345678, 0);
        set_vec(9,  1, 0, 3'b010, 32'h02, 0, 0, 0, 1, 0, 0, 0);
        set_vec(10, 1, 0, 3'b001, 32'h01, 0, 0, 0, 1, 0, 0, 0);
        set_vec(11, 1, 0, 3'b011, 32'h00, 0, 0, 0, 1, 0, 0, 0);
        set_vec(12, 0, 1, 3'b100, 32'h00, 0, 0, 0, 1, 0, 0, 0);
        set_vec(13, 1, 1, 3'b010, 32'h00, 0, 0, 0, 1, 0, 0, 0);
        set_vec(14, 1, 0, 3'b000, 32'h01, 0, 32'h00007F00, 1, 0, 4'hF, 0, 32'h0000007F);
        set_vec(15, 1, 0, 3'b001, 32'h02, 0, 32'h9ABC1234, 2, 0, 4'hF, 0, 32'hFFFF9ABC);

        reset        = 1'b1;
        ex_mem_in    = '0;
        ex_mem_valid = 1'b0;
        mem_ready    = 1'b0;
        mem_rdata    = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_req", 256'(mem_req), 256'(0));
        check("rst_stall", 256'(mem_stall), 256'(0));
        check("rst_valid", 256'(mem_wb_valid), 256'(0));
        check("rst_fault", 256'(mem_fault), 256'(0));
        check("rst_wb", 256'(mem_wb_out), 256'(0));
        check("rst_addr", 256'(mem_addr), 256'(0));
        check("rst_be", 256'(mem_be), 256'(0));

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Bubble with non-zero fields and a stray mem_ready in IDLE.
        @(negedge clk);
        ex_mem_in    = make_ex(vecs[0], 20);
        ex_mem_valid = 1'b0;
        mem_ready    = 1'b1;
        #1;
        check("bubble_stall", 256'(mem_stall), 256'(0));
        @(negedge clk);
        mem_ready = 1'b0;
        check("bubble_valid", 256'(mem_wb_valid), 256'(0));
        check("bubble_wb", 256'(mem_wb_out), 256'(0));
        check("bubble_req", 256'(mem_req), 256'(0));

        // Reset in the 2nd REQ cycle, coinciding with mem_ready.
        e = make_ex(vecs[1], 21);
        @(negedge clk);
        ex_mem_in    = e;
        ex_mem_valid = 1'b1;
        mem_rdata    = 32'h11111111;
        @(negedge clk);
        check("rreq_req1", 256'(mem_req), 256'(1));
        @(negedge clk);
        check("rreq_req2", 256'(mem_req), 256'(1));
        reset     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        mem_ready    = 1'b0;
        ex_mem_valid = 1'b0;
        #1;
        check("rreq_req_drop", 256'(mem_req), 256'(0));
        check("rreq_valid", 256'(mem_wb_valid), 256'(0));
        check("rreq_stall", 256'(mem_stall), 256'(0));
        @(negedge clk);
        check("rreq_no_done", 256'(mem_wb_valid), 256'(0));
        check("rreq_idle_req", 256'(mem_req), 256'(0));
        run_vec(vecs[0], 22);

        check("sb_empty", 256'(sb_q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
